// File: rtl/ucie_rdi_tx_packer.sv
// UCIe channel-adapter TX packer: gathers DW-bit words into one RDI mainband beat.
// A timeout or an explicit flush sends a partial beat, with the unused slots padded.
module ucie_rdi_tx_packer #(
    parameter int             DW           = 64,
    parameter int             NSLOT        = 6,
    parameter int             FLUSH_CYCLES = 16,
    parameter logic [DW-1:0]  PAD_WORD     = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DW*NSLOT-1:0]   lp_data,
    output logic                  lp_valid,
    output logic                  lp_irdy,
    input  logic                  pl_trdy,
    output logic [15:0]           o_beat_cnt,
    output logic [15:0]           o_pad_cnt,
    output logic                  o_busy
);

    localparam int CW = $clog2(NSLOT);
    localparam int TW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLOT - 1);
    localparam logic [TW-1:0] TMAX = TW'(FLUSH_CYCLES - 1);

    generate
        if (DW * NSLOT != 384 || FLUSH_CYCLES < 1) begin : g_bad_param
            $error("ucie_rdi_tx_packer: DW*NSLOT must be 384 and FLUSH_CYCLES >= 1");
        end
    endgenerate

    // The last slot is never stored; the word completing a beat goes directly to the output register.
    logic [DW-1:0]        asm_q [NSLOT-1];
    logic [CW-1:0]        asm_cnt;
    logic [TW-1:0]        idle_tmr;
    logic                 flush_pend;
    logic                 out_free;
    logic                 accept;
    logic                 full_now;
    logic                 timeout;
    logic                 flush_req;
    logic                 load_part;
    logic                 load_beat;
    logic                 clear_pend;
    logic [DW*NSLOT-1:0]  next_beat;

    always_comb begin
        out_free   = !lp_valid || pl_trdy;
        in_ready   = rst_n && i_enable && ((asm_cnt < LAST) || out_free);
        accept     = in_valid && in_ready;
        full_now   = accept && (asm_cnt == LAST);
        timeout    = (idle_tmr == TMAX) && (asm_cnt != '0) && !accept;
        flush_req  = flush_pend || i_flush || timeout;
        load_part  = flush_req && out_free && !full_now && ((asm_cnt != '0) || accept);
        load_beat  = full_now || load_part;
        clear_pend = full_now || (flush_req && (out_free || ((asm_cnt == '0) && !accept)));
    end

    always_comb begin
        next_beat = '0;
        for (int k = 0; k < NSLOT; k++) begin
            next_beat[k*DW +: DW] = PAD_WORD;
            if (accept && (asm_cnt == CW'(k)))
                next_beat[k*DW +: DW] = in_data;
        end
        for (int k = 0; k < NSLOT - 1; k++) begin
            if (CW'(k) < asm_cnt)
                next_beat[k*DW +: DW] = asm_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_cnt <= '0;
            for (int k = 0; k < NSLOT - 1; k++)
                asm_q[k] <= '0;
        end else if (load_beat) begin
            asm_cnt <= '0;
        end else if (accept) begin
            for (int k = 0; k < NSLOT - 1; k++)
                if (asm_cnt == CW'(k))
                    asm_q[k] <= in_data;
            asm_cnt <= asm_cnt + CW'(1);
        end
    end

    // Idle timer saturates so a blocked timeout keeps requesting until the output frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_tmr   <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (asm_cnt == '0 || accept || load_beat)
                idle_tmr <= '0;
            else if (idle_tmr != TMAX)
                idle_tmr <= idle_tmr + TW'(1);
            if (clear_pend)
                flush_pend <= 1'b0;
            else if (i_flush)
                flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_data    <= '0;
            lp_valid   <= 1'b0;
            o_beat_cnt <= '0;
            o_pad_cnt  <= '0;
        end else begin
            if (load_beat) begin
                lp_data  <= next_beat;
                lp_valid <= 1'b1;
            end else if (pl_trdy) begin
                lp_valid <= 1'b0;
            end
            if (lp_valid && pl_trdy && o_beat_cnt != 16'hFFFF)
                o_beat_cnt <= o_beat_cnt + 16'd1;
            if (load_part && o_pad_cnt != 16'hFFFF)
                o_pad_cnt <= o_pad_cnt + 16'd1;
        end
    end

    assign lp_irdy = lp_valid;
    assign o_busy  = (asm_cnt != '0) || lp_valid;

endmodule

// File: tb/tb_ucie_rdi_tx_packer.sv
// Scoreboard bench for ucie_rdi_tx_packer: expected beats are queued as words are driven,
// and a monitor pops and compares them on every RDI transfer.
module tb_ucie_rdi_tx_packer;

    localparam int BW = 384;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_enable = 1'b0;
    logic            i_flush = 1'b0;
    logic [63:0]     in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BW-1:0]   lp_data;
    logic            lp_valid;
    logic            lp_irdy;
    logic            pl_trdy = 1'b0;
    logic [15:0]     o_beat_cnt;
    logic [15:0]     o_pad_cnt;
    logic            o_busy;

    int total = 0;
    int bad = 0;
    logic [BW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ucie_rdi_tx_packer #(
        .DW(64), .NSLOT(6), .FLUSH_CYCLES(16), .PAD_WORD(64'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_flush(i_flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .lp_data(lp_data), .lp_valid(lp_valid), .lp_irdy(lp_irdy), .pl_trdy(pl_trdy),
        .o_beat_cnt(o_beat_cnt), .o_pad_cnt(o_pad_cnt), .o_busy(o_busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, actual, expected);
        end
    endtask

    // Words base, base+1, ... in slots 0.. n-1; remaining slots hold the zero pad word.
    function automatic logic [BW-1:0] beatOf(input logic [63:0] base, input int n);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < n; k++)
            b[k*64 +: 64] = base + 64'(k);
        return b;
    endfunction

    // Monitor: every transfer must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && lp_valid && pl_trdy) begin
            checkOutput("irdy", lp_irdy, lp_valid);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL beat: got=%h want=none", lp_data);
            end else begin
                if (lp_data !== exp_q[0]) begin
                    bad++;
                    $display("[TB] FAIL beat: got=%h want=%h", lp_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic sendWord(input logic [63:0] w);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 50) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got=stalled want=accepted word %0h", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++)
            sendWord(base + 64'(k));
    endtask

    task automatic drain(input string name);
        logic pending;
        pending = 1'b1;
        for (int n = 0; n < 100 && pending; n++) begin
            @(negedge clk);
            pending = (exp_q.size() != 0) || lp_valid;
        end
        checkOutput({name, "_drain"}, pending, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        i_enable = 1'b1;
        pl_trdy  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_lp_valid", lp_valid, 0);
        checkOutput("rst_lp_irdy", lp_irdy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_beat_cnt", o_beat_cnt, 0);
        checkOutput("rst_pad_cnt", o_pad_cnt, 0);
        checkOutput("rst_lp_data_nz", lp_data != '0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Six back-to-back words form one beat one cycle after the sixth.
        exp_q.push_back(beatOf(64'd1, 6));
        applyStimulus(64'd1, 5);
        checkOutput("t1_valid_before", lp_valid, 0);
        sendWord(64'd6);
        @(negedge clk);
        checkOutput("t1_valid_after", lp_valid, 1);
        @(posedge clk);
        #1;
        drain("t1");
        checkOutput("t1_beat_cnt", o_beat_cnt, 1);
        checkOutput("t1_pad_cnt", o_pad_cnt, 0);

        // Back-pressure: the twelfth word stalls until the held beat transfers.
        pl_trdy = 1'b0;
        exp_q.push_back(beatOf(64'd101, 6));
        exp_q.push_back(beatOf(64'd107, 6));
        applyStimulus(64'd101, 11);
        in_data  = 64'd112;
        in_valid = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready) n++;
        end
        checkOutput("t2_in_ready_stalled", n, 0);
        checkOutput("t2_held_data_ok", lp_data == beatOf(64'd101, 6), 1);
        @(posedge clk);
        #1;
        pl_trdy = 1'b1;
        sendWord(64'd112);
        @(negedge clk);
        checkOutput("t2_back_to_back", lp_valid, 1);
        @(posedge clk);
        #1;
        drain("t2");
        checkOutput("t2_beat_cnt", o_beat_cnt, 3);

        // Two words then idle: padded beat 17 cycles after the second word.
        exp_q.push_back(beatOf(64'hAAAA_0000_0000_0000, 2));
        applyStimulus(64'hAAAA_0000_0000_0000, 2);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (lp_valid) break;
        end
        checkOutput("t3_timeout_latency", n, 17);
        @(posedge clk);
        #1;
        drain("t3");
        checkOutput("t3_pad_cnt", o_pad_cnt, 1);
        checkOutput("t3_beat_cnt", o_beat_cnt, 4);

        // Flush on an empty assembly does nothing; flush with the sixth word gives a full beat.
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t4_empty_flush_valid", lp_valid, 0);
        checkOutput("t4_empty_flush_busy", o_busy, 0);
        @(posedge clk);
        #1;
        exp_q.push_back(beatOf(64'd201, 6));
        applyStimulus(64'd201, 5);
        i_flush = 1'b1;
        sendWord(64'd206);
        i_flush = 1'b0;
        drain("t4");
        checkOutput("t4_pad_cnt", o_pad_cnt, 1);
        checkOutput("t4_beat_cnt", o_beat_cnt, 5);

        // Flush while the output is held waits, then the padded beat follows directly.
        pl_trdy = 1'b0;
        exp_q.push_back(beatOf(64'd301, 6));
        exp_q.push_back(beatOf(64'd307, 3));
        applyStimulus(64'd301, 9);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_held_valid", lp_valid, 1);
        checkOutput("t5_held_data_ok", lp_data == beatOf(64'd301, 6), 1);
        checkOutput("t5_busy", o_busy, 1);
        checkOutput("t5_pad_not_yet", o_pad_cnt, 1);
        @(posedge clk);
        #1;
        pl_trdy = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t5_padded_follows", lp_valid, 1);
        @(posedge clk);
        #1;
        drain("t5");
        checkOutput("t5_pad_cnt", o_pad_cnt, 2);
        checkOutput("t5_beat_cnt", o_beat_cnt, 7);

        // Disabled input still lets a pending partial beat time out.
        exp_q.push_back(beatOf(64'd401, 2));
        applyStimulus(64'd401, 2);
        i_enable = 1'b0;
        @(negedge clk);
        checkOutput("t7_disabled_ready", in_ready, 0);
        @(posedge clk);
        #1;
        drain("t7");
        i_enable = 1'b1;
        checkOutput("t7_pad_cnt", o_pad_cnt, 3);
        checkOutput("t7_beat_cnt", o_beat_cnt, 8);

        // Reset with a held beat and four assembled words discards everything.
        pl_trdy = 1'b0;
        applyStimulus(64'd501, 10);
        @(negedge clk);
        checkOutput("t6_pre_valid", lp_valid, 1);
        checkOutput("t6_pre_busy", o_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", lp_valid, 0);
        checkOutput("t6_rst_irdy", lp_irdy, 0);
        checkOutput("t6_rst_beat_cnt", o_beat_cnt, 0);
        checkOutput("t6_rst_pad_cnt", o_pad_cnt, 0);
        checkOutput("t6_rst_busy", o_busy, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pl_trdy = 1'b1;
        exp_q.push_back(beatOf(64'd601, 6));
        applyStimulus(64'd601, 6);
        drain("t6");
        checkOutput("t6_beat_cnt", o_beat_cnt, 1);
        checkOutput("t6_pad_cnt", o_pad_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
